mem_port_arbiter: RTL and testbench

- Arbitrates the single external memory bus between instruction fetch (driven from the PC register's fetch address/enable) and the MEM stage (load/store).
- Sequences each access as a request/acknowledge transaction and returns the result to the owning side.
- Raises per-side stall requests toward ctrl while an access is pending.
- Discards an in-flight fetch on a branch redirect, and completes a transaction with an error if it times out.

---
 rtl/mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single external memory bus between instruction fetch and the
// MEM stage. Each access is one request/acknowledge transaction; the result
// is returned to the side that owns it as a one-cycle pulse. The MEM stage
// wins when both sides want the bus in the same cycle. A branch redirect
// kills an in-flight fetch (the bus transaction still runs to its ack so the
// slave is never left mid-cycle), and a transaction that waits TIMEOUT cycles
// without an ack is abandoned and completed with err_o.
//
// Parameters:
//   TIMEOUT  cycles bus_req_o may wait for bus_ack_i (>= 2)
//   CNT_W    wait-counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   if_ce_i, if_addr_i, flush_i   fetch request and branch-redirect kill
//   if_data_o, if_valid_o         fetched word, one-cycle valid pulse
//   stallreq_if_o                 fetch stall request to ctrl
//   mem_req_i, mem_we_i,
//   mem_sel_i, mem_addr_i,
//   mem_wdata_i                   MEM-stage access, held until mem_done_o
//   mem_rdata_o, mem_done_o       load data, one-cycle completion pulse
//   stallreq_mem_o                MEM stall request to ctrl
//   bus_req_o, bus_we_o,
//   bus_sel_o, bus_addr_o,
//   bus_wdata_o                   registered bus master outputs
//   bus_rdata_i, bus_ack_i        bus slave response (ack is single cycle)
//   err_o                         pulse accompanying a timeout completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    input  logic        flush_i,
    output logic [31:0] if_data_o,
    output logic        if_valid_o,
    output logic        stallreq_if_o,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        stallreq_mem_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        err_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_IF_BUSY  = 2'd1;
    localparam logic [1:0] S_IF_DROP  = 2'd2;
    localparam logic [1:0] S_MEM_BUSY = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             r_bus_req;
    logic             r_bus_we;
    logic [3:0]       r_bus_sel;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;

    logic [31:0]      r_if_data;
    logic             r_if_valid;
    logic [31:0]      r_mem_rdata;
    logic             r_mem_done;
    logic             r_err;

    // Last busy cycle the slave is given before the access is abandoned.
    logic             w_timeout;
    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'h0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_if_data   <= 32'h0;
            r_if_valid  <= 1'b0;
            r_mem_rdata <= 32'h0;
            r_mem_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // branch below sees the pre-edge values; the completion pulses
            // default low here and are raised for exactly one cycle below.
            r_if_valid <= 1'b0;
            r_mem_done <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // The done/valid guards stop a requester that is still
                    // holding its request in the pulse cycle from re-issuing.
                    if (mem_req_i && !r_mem_done) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_we_i;
                        r_bus_sel   <= mem_sel_i;
                        r_bus_addr  <= mem_addr_i;
                        r_bus_wdata <= mem_wdata_i;
                        r_cnt       <= '0;
                        r_state     <= S_MEM_BUSY;
                    end else if (if_ce_i && !flush_i && !r_if_valid) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_sel   <= 4'hF;
                        r_bus_addr  <= if_addr_i;
                        r_bus_wdata <= 32'h0;
                        r_cnt       <= '0;
                        r_state     <= S_IF_BUSY;
                    end
                end

                S_MEM_BUSY: begin
                    if (bus_ack_i) begin
                        r_bus_req  <= 1'b0;
                        r_mem_done <= 1'b1;
                        if (!r_bus_we) begin
                            r_mem_rdata <= bus_rdata_i;
                        end
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_bus_req   <= 1'b0;
                        r_mem_done  <= 1'b1;
                        r_mem_rdata <= 32'h0;
                        r_err       <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_IF_BUSY: begin
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        if (!flush_i) begin
                            r_if_data  <= bus_rdata_i;
                            r_if_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_err     <= 1'b1;
                        if (!flush_i) begin
                            r_if_data  <= 32'h0;
                            r_if_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        // Killed fetch: keep the bus cycle alive until the
                        // slave answers, but never deliver its data.
                        if (flush_i) begin
                            r_state <= S_IF_DROP;
                        end
                    end
                end

                S_IF_DROP: begin
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_sel_o   = r_bus_sel;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;

    assign if_data_o   = r_if_data;
    assign if_valid_o  = r_if_valid;
    assign mem_rdata_o = r_mem_rdata;
    assign mem_done_o  = r_mem_done;
    assign err_o       = r_err;

    // Stall requests follow the requester directly; reset forces them low
    // immediately so ctrl is released without waiting for a clock edge.
    assign stallreq_mem_o = ~rst & mem_req_i & ~r_mem_done;
    assign stallreq_if_o  = ~rst & if_ce_i & ~r_if_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios for mem_port_arbiter. Each scenario queues the bus
// transactions it expects to see issued, the slave response to give each one,
// and the completions it expects back; independent monitors pop and compare.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic        flush_i;
    logic [31:0] if_data_o;
    logic        if_valid_o;
    logic        stallreq_if_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        stallreq_mem_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        err_o;

    mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .flush_i        (flush_i),
        .if_data_o      (if_data_o),
        .if_valid_o     (if_valid_o),
        .stallreq_if_o  (stallreq_if_o),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_done_o     (mem_done_o),
        .stallreq_mem_o (stallreq_mem_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } issue_t;

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
        logic        err;
    } cpl_t;

    typedef struct {
        int          delay;   // 0 = never acknowledge
        logic [31:0] rdata;
    } resp_t;

    issue_t iq[$];
    cpl_t   cq[$];
    resp_t  rq[$];

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic exp_issue(input logic we, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] wdata);
        issue_t e;
        e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata;
        iq.push_back(e);
    endtask

    task automatic exp_cpl(input logic is_mem, input logic [31:0] data, input logic err);
        cpl_t c;
        c.is_mem = is_mem; c.data = data; c.err = err;
        cq.push_back(c);
    endtask

    task automatic slave_resp(input int delay, input logic [31:0] rdata);
        resp_t r;
        r.delay = delay; r.rdata = rdata;
        rq.push_back(r);
    endtask

    // Bus slave: acknowledges the delay-th cycle after bus_req_o rises.
    initial begin
        resp_t cur;
        int    cnt;
        bit    active;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        cnt         = 0;
        active      = 1'b0;
        cur.delay   = 0;
        cur.rdata   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus_ack_i = 1'b0;
                active    = 1'b0;
            end else if (bus_ack_i) begin
                bus_ack_i   = 1'b0;
                bus_rdata_i = 32'hBAD0BAD0;
                active      = 1'b0;
            end else if (bus_req_o) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    if (rq.size() != 0) cur = rq.pop_front();
                    else begin cur.delay = 0; cur.rdata = 32'h0; end
                end
                cnt++;
                if (cur.delay != 0 && cnt == cur.delay) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = cur.rdata;
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    // Bus monitor: checks each new issue and that the bus stays stable.
    initial begin
        issue_t e;
        logic   prev;
        prev = 1'b0;
        e.we = 1'b0; e.sel = 4'h0; e.addr = 32'h0; e.wdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bus_req_o && !prev) begin
                    if (iq.size() == 0) begin
                        check("unexpected_issue", 32'(bus_addr_o), 32'hFFFFFFFF);
                    end else begin
                        e = iq.pop_front();
                        check("issue_addr",  bus_addr_o,         e.addr);
                        check("issue_sel",   32'(bus_sel_o),     32'(e.sel));
                        check("issue_we",    32'(bus_we_o),      32'(e.we));
                        check("issue_wdata", bus_wdata_o,        e.wdata);
                    end
                end else if (bus_req_o) begin
                    check("stable_addr",  bus_addr_o, e.addr);
                    check("stable_ctrl",  32'({bus_we_o, bus_sel_o}), 32'({e.we, e.sel}));
                end
                prev = bus_req_o;
            end
        end
    end

    // Completion monitor: every valid/done pulse must match the scoreboard.
    initial begin
        cpl_t c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_valid_o && mem_done_o) begin
                    check("double_pulse", 32'(if_valid_o & mem_done_o), 32'h0);
                end else if (if_valid_o || mem_done_o) begin
                    if (cq.size() == 0) begin
                        check("unexpected_cpl", 32'({if_valid_o, mem_done_o}), 32'h0);
                    end else begin
                        c = cq.pop_front();
                        check("cpl_side", 32'(mem_done_o), 32'(c.is_mem));
                        check("cpl_data", c.is_mem ? mem_rdata_o : if_data_o, c.data);
                        check("cpl_err",  32'(err_o), 32'(c.err));
                    end
                end else if (err_o) begin
                    check("stray_err", 32'(err_o), 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_pulse(input string tag, input bit is_mem, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = is_mem ? mem_done_o : if_valid_o;
        end
        if (!seen) check(tag, 32'h0, 32'h1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic we, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] wdata);
        mem_we_i    = we;
        mem_sel_i   = sel;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_req_i   = 1'b1;
    endtask

    initial begin
        int  hi_cycles;
        bit  done;
        rst         = 1'b1;
        if_ce_i     = 1'b0;
        if_addr_i   = 32'h0;
        flush_i     = 1'b0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = 4'h0;
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req",   32'(bus_req_o),      32'h0);
        check("rst_bus_addr",  bus_addr_o,          32'h0);
        check("rst_bus_sel",   32'(bus_sel_o),      32'h0);
        check("rst_if_valid",  32'(if_valid_o),     32'h0);
        check("rst_mem_done",  32'(mem_done_o),     32'h0);
        check("rst_err",       32'(err_o),          32'h0);
        check("rst_mem_rdata", mem_rdata_o,         32'h0);
        check("rst_if_data",   if_data_o,           32'h0);
        rst = 1'b0;
        tick();

        // ---- fetch only ----
        slave_resp(2, 32'h24010005);
        exp_issue(1'b0, 4'hF, 32'h100, 32'h0);
        exp_cpl(1'b0, 32'h24010005, 1'b0);
        if_ce_i   = 1'b1;
        if_addr_i = 32'h100;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (if_valid_o) begin
                check("fetch_stall_in_valid", 32'(stallreq_if_o), 32'h0);
                done = 1'b1;
            end else begin
                check("fetch_stall_busy", 32'(stallreq_if_o), 32'h1);
            end
        end
        if (!done) check("fetch_valid_timeout", 32'h0, 32'h1);
        tick();
        if_ce_i = 1'b0;
        repeat (3) tick();

        // ---- priority: MEM and fetch together ----
        slave_resp(1, 32'h11112222);
        slave_resp(1, 32'h33334444);
        exp_issue(1'b0, 4'hF, 32'h2000, 32'h5555AAAA);
        exp_issue(1'b0, 4'hF, 32'h300,  32'h0);
        exp_cpl(1'b1, 32'h11112222, 1'b0);
        exp_cpl(1'b0, 32'h33334444, 1'b0);
        drive_mem(1'b0, 4'hF, 32'h2000, 32'h5555AAAA);
        if_ce_i   = 1'b1;
        if_addr_i = 32'h300;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_done_o) begin
                check("prio_stall_mem_done", 32'(stallreq_mem_o), 32'h0);
                check("prio_stall_if_wait",  32'(stallreq_if_o),  32'h1);
                check("prio_req_idle",       32'(bus_req_o),      32'h0);
                done = 1'b1;
            end else begin
                check("prio_stall_mem", 32'(stallreq_mem_o), 32'h1);
                check("prio_stall_if",  32'(stallreq_if_o),  32'h1);
            end
        end
        if (!done) check("prio_mem_timeout", 32'h0, 32'h1);
        tick();
        mem_req_i = 1'b0;
        @(negedge clk);
        check("prio_fetch_issue_req",  32'(bus_req_o), 32'h1);
        check("prio_fetch_issue_addr", bus_addr_o,     32'h300);
        wait_pulse("prio_fetch_timeout", 1'b0, 20);
        tick();
        if_ce_i = 1'b0;
        repeat (2) tick();

        // ---- flush while the fetch is on the bus ----
        slave_resp(4, 32'hAAAA0001);
        slave_resp(1, 32'h0500DA7A);
        exp_issue(1'b0, 4'hF, 32'h400, 32'h0);
        exp_issue(1'b0, 4'hF, 32'h500, 32'h0);
        exp_cpl(1'b0, 32'h0500DA7A, 1'b0);
        if_ce_i   = 1'b1;
        if_addr_i = 32'h400;
        tick();
        flush_i   = 1'b1;
        if_addr_i = 32'h500;
        tick();
        flush_i   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            check("flush_req_held", 32'(bus_req_o), 32'h1);
            done = bus_ack_i;
        end
        if (!done) check("flush_ack_timeout", 32'h0, 32'h1);
        @(negedge clk);
        check("flush_req_dropped", 32'(bus_req_o),  32'h0);
        check("flush_no_valid",    32'(if_valid_o), 32'h0);
        wait_pulse("flush_refetch_timeout", 1'b0, 20);
        tick();
        if_ce_i = 1'b0;
        repeat (2) tick();

        // ---- store: rdata keeps the last load value ----
        slave_resp(1, 32'hFFFFFFFF);
        exp_issue(1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF);
        exp_cpl(1'b1, 32'h11112222, 1'b0);
        drive_mem(1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF);
        wait_pulse("store_done_timeout", 1'b1, 20);
        tick();
        mem_req_i = 1'b0;
        repeat (2) tick();

        // ---- load timeout ----
        slave_resp(0, 32'h0);
        exp_issue(1'b0, 4'hF, 32'h4000, 32'h0);
        exp_cpl(1'b1, 32'h0, 1'b1);
        drive_mem(1'b0, 4'hF, 32'h4000, 32'h0);
        hi_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_done_o) begin
                check("timeout_err_with_done", 32'(err_o),     32'h1);
                check("timeout_req_dropped",   32'(bus_req_o), 32'h0);
                done = 1'b1;
            end else if (bus_req_o) begin
                hi_cycles++;
            end
        end
        if (!done) check("timeout_done_missing", 32'h0, 32'h1);
        check("timeout_req_cycles", 32'(hi_cycles), 32'd16);
        tick();
        mem_req_i = 1'b0;
        repeat (2) tick();

        // ---- asynchronous reset in the middle of a MEM access ----
        slave_resp(0, 32'h0);
        exp_issue(1'b0, 4'hF, 32'h5000, 32'h0);
        if_ce_i   = 1'b1;
        if_addr_i = 32'h600;
        drive_mem(1'b0, 4'hF, 32'h5000, 32'h0);
        repeat (3) @(negedge clk);
        check("rstmid_busy_req", 32'(bus_req_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_bus_req",     32'(bus_req_o),      32'h0);
        check("rstmid_mem_done",    32'(mem_done_o),     32'h0);
        check("rstmid_stall_mem",   32'(stallreq_mem_o), 32'h0);
        check("rstmid_stall_if",    32'(stallreq_if_o),  32'h0);
        check("rstmid_mem_rdata",   mem_rdata_o,         32'h0);
        if_ce_i = 1'b0;
        repeat (2) @(posedge clk);
        slave_resp(2, 32'hC0FFEE00);
        exp_issue(1'b0, 4'hF, 32'h5000, 32'h0);
        exp_cpl(1'b1, 32'hC0FFEE00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_pulse("rstmid_reissue_timeout", 1'b1, 20);
        tick();
        mem_req_i = 1'b0;
        repeat (4) tick();

        check("issue_queue_empty", 32'(iq.size()), 32'h0);
        check("cpl_queue_empty",   32'(cq.size()), 32'h0);
        check("resp_queue_empty",  32'(rq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
